// File: rtl/keypad_input.sv
// Keypad entry block: collects up to MAX_DIGITS decimal digits from the board switches,
// one per debounced press of key_digit_n, and hands the value to a stalled IN instruction
// when key_done_n is pressed.
// Optional feature: define KEYPAD_INPUT_NEG_EN to let sw_neg negate the delivered value.

module keypad_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MAX_DIGITS      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sw_digit,
  input  logic        sw_neg,
  input  logic        key_digit_n,
  input  logic        key_done_n,
  input  logic        in_req,
  output logic        in_valid,
  output logic [31:0] in_data,
  output logic [31:0] entry_val,
  output logic        entry_busy
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam logic [DbW-1:0]  DbMax    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(MAX_DIGITS);

  typedef enum logic [1:0] {StIdle, StEntry, StDeliver} state_e;

  // Bit 0 is the digit key, bit 1 the done key; both active-low.
  logic [1:0]     key_raw;
  logic [1:0]     sync1_q;
  logic [1:0]     sync2_q;
  logic [1:0]     stable_q;
  logic [1:0]     press_evt_q;
  logic [DbW-1:0] db_cnt_q [2];

  state_e          state_q;
  logic [31:0]     acc_q;
  logic [CntW-1:0] count_q;

  logic        digit_evt;
  logic        done_evt;
  logic        digit_ok;
  logic [31:0] acc_next;
  logic [31:0] result;

  assign key_raw   = {key_done_n, key_digit_n};
  assign digit_evt = press_evt_q[0];
  assign done_evt  = press_evt_q[1];

  // Synchronise both keys, debounce them and emit a one-cycle pulse on each accepted press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      stable_q    <= 2'b11;
      press_evt_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      press_evt_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == stable_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DbMax) begin
          // DEBOUNCE_CYCLES identical differing samples seen: accept the new level.
          db_cnt_q[k]    <= '0;
          stable_q[k]    <= sync2_q[k];
          press_evt_q[k] <= ~sync2_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DbW'(1);
        end
      end
    end
  end

  // Digit acceptance, next accumulator value and the value handed over on done.
  always_comb begin
    digit_ok = digit_evt && (sw_digit <= 4'd9) && (count_q < CntLimit);
    acc_next = (acc_q * 32'd10) + {28'd0, sw_digit};
`ifdef KEYPAD_INPUT_NEG_EN
    result   = sw_neg ? (~acc_q + 32'd1) : acc_q;
`else
    result   = acc_q;
`endif
  end

`ifndef KEYPAD_INPUT_NEG_EN
  logic unused_sw_neg;
  assign unused_sw_neg = sw_neg;
`endif

  // Entry FSM; in_valid and in_data are registered so the pulse lands one cycle after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      count_q  <= '0;
      in_valid <= 1'b0;
      in_data  <= '0;
    end else begin
      in_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_req) begin
            state_q <= StEntry;
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        StEntry: begin
          if (!in_req) begin
            // Request withdrawn: drop the partial entry, leave in_data alone.
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
          end else if (done_evt) begin
            // Done wins over a coincident digit press.
            in_data  <= result;
            in_valid <= 1'b1;
            state_q  <= StDeliver;
          end else if (digit_ok) begin
            acc_q   <= acc_next;
            count_q <= count_q + CntW'(1);
          end
        end
        StDeliver: begin
          if (!in_req) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign entry_val  = acc_q;
  assign entry_busy = (state_q == StEntry);

endmodule
